// File: rtl/bcd_clock_pkg.sv
// Shared constants and BCD increment helper for the time-of-day counter and
// the digit display logic.
package bcd_clock_pkg;

    localparam int unsigned BCD_W = 8;

    localparam logic [BCD_W-1:0] SECS_MAX  = 8'h59;
    localparam logic [BCD_W-1:0] MINS_MAX  = 8'h59;
    localparam logic [BCD_W-1:0] HRS24_MAX = 8'h23;
    localparam logic [BCD_W-1:0] HRS12_MIN = 8'h01;
    localparam logic [BCD_W-1:0] HRS12_MAX = 8'h12;

    // Next BCD value of a two-digit field; anything illegal snaps to 00.
    function automatic logic [BCD_W-1:0] bcd_inc(
        input logic [BCD_W-1:0] val,
        input logic [BCD_W-1:0] max,
        input logic [BCD_W-1:0] wrap_to
    );
        logic [BCD_W-1:0] res;
        if ((val[7:4] > 4'd9) || (val[3:0] > 4'd9) || (val > max)) begin
            res = 8'h00;
        end else if (val == max) begin
            res = wrap_to;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'h0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// Two-digit BCD field counter with clear, increment-with-wrap and a carry
// flag raised when an increment rolls the field over from MAX.
module bcd_field_counter
    import bcd_clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX     = 8'h59,
    parameter logic [BCD_W-1:0] WRAP_TO = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BCD_W-1:0] reset_value,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] value,
    output logic             carry_out
);

    logic [BCD_W-1:0] value_r;

    // Field register: reset, then clear, then increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= reset_value;
        end else if (clr) begin
            value_r <= 8'h00;
        end else if (inc) begin
            value_r <= bcd_inc(value_r, MAX, WRAP_TO);
        end else begin
            value_r <= value_r;
        end
    end

    assign value     = value_r;
    assign carry_out = inc & ~clr & (value_r == MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// BCD time-of-day counter (hh:mm:ss) driven by a 1 Hz tick and adjust pulses.
// Define BCD_CLOCK_12H_EN for 12-hour counting with a PM indicator.
module bcd_time_counter
    import bcd_clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] RESET_HRS  = 8'h12,
    parameter logic [BCD_W-1:0] RESET_MINS = 8'h00,
    parameter logic [BCD_W-1:0] RESET_SECS = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             adj_hrs,
    input  logic             adj_mins,
    input  logic             adj_secs,
    output logic [BCD_W-1:0] hrs,
    output logic [BCD_W-1:0] mins,
    output logic [BCD_W-1:0] secs,
    output logic             day_wrap,
    output logic             pm
);

`ifdef BCD_CLOCK_12H_EN
    localparam logic [BCD_W-1:0] HRS_MAX  = HRS12_MAX;
    localparam logic [BCD_W-1:0] HRS_WRAP = HRS12_MIN;
`else
    localparam logic [BCD_W-1:0] HRS_MAX  = HRS24_MAX;
    localparam logic [BCD_W-1:0] HRS_WRAP = 8'h00;
`endif

    logic tick_only_s;
    logic secs_carry_s;
    logic mins_inc_s;
    logic mins_carry_s;
    logic hrs_inc_s;
    logic hrs_carry_s;
    logic day_wrap_s;
    logic pm_next_s;
    logic day_wrap_r;
    logic pm_r;

    // Any adjust pulse drops the tick; adjusts never carry between fields.
    assign tick_only_s = tick & ~(adj_hrs | adj_mins | adj_secs);
    assign mins_inc_s  = adj_mins | secs_carry_s;
    assign hrs_inc_s   = adj_hrs | (mins_carry_s & tick_only_s);

`ifdef BCD_CLOCK_12H_EN
    assign day_wrap_s = tick_only_s & mins_carry_s & (hrs == 8'h11) & pm_r;
    assign pm_next_s  = pm_r ^ (hrs_inc_s & (hrs == 8'h11));
`else
    assign day_wrap_s = tick_only_s & hrs_carry_s;
    assign pm_next_s  = 1'b0;
`endif

    bcd_field_counter #(.MAX(SECS_MAX), .WRAP_TO(8'h00)) u_secs (
        .clk         (clk),
        .reset       (reset),
        .reset_value (RESET_SECS),
        .inc         (tick_only_s),
        .clr         (adj_secs),
        .value       (secs),
        .carry_out   (secs_carry_s)
    );

    bcd_field_counter #(.MAX(MINS_MAX), .WRAP_TO(8'h00)) u_mins (
        .clk         (clk),
        .reset       (reset),
        .reset_value (RESET_MINS),
        .inc         (mins_inc_s),
        .clr         (1'b0),
        .value       (mins),
        .carry_out   (mins_carry_s)
    );

    bcd_field_counter #(.MAX(HRS_MAX), .WRAP_TO(HRS_WRAP)) u_hrs (
        .clk         (clk),
        .reset       (reset),
        .reset_value (RESET_HRS),
        .inc         (hrs_inc_s),
        .clr         (1'b0),
        .value       (hrs),
        .carry_out   (hrs_carry_s)
    );

    // Day-wrap strobe and PM flag, registered alongside the field updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            day_wrap_r <= 1'b0;
            pm_r       <= 1'b0;
        end else begin
            day_wrap_r <= day_wrap_s;
            pm_r       <= pm_next_s;
        end
    end

    assign day_wrap = day_wrap_r;
    assign pm       = pm_r;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench: integer time-of-day model compared every cycle, plus
// directed literal checks and randomized strobes.
module tb_bcd_time_counter;

    logic       clk = 1'b0;
    logic       reset, tick, adj_hrs, adj_mins, adj_secs;
    logic [7:0] hrs, mins, secs;
    logic       day_wrap, pm;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       dw;
        logic       pm;
    } mstate_t;

    mstate_t mdl;

    bcd_time_counter dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .adj_hrs  (adj_hrs),
        .adj_mins (adj_mins),
        .adj_secs (adj_secs),
        .hrs      (hrs),
        .mins     (mins),
        .secs     (secs),
        .day_wrap (day_wrap),
        .pm       (pm)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int next_hour(input int h);
`ifdef BCD_CLOCK_12H_EN
        return (h == 12) ? 1 : h + 1;
`else
        return (h + 1) % 24;
`endif
    endfunction

    // One clock of the time-of-day rules, in plain integer arithmetic.
    function automatic mstate_t step(input mstate_t c, input logic r, input logic t,
                                     input logic ah, input logic am, input logic as);
        mstate_t n;
        int h, m, s;
        bit hour_adv;
        n = c;
        n.dw = 1'b0;
        h = int'(c.h); m = int'(c.m); s = int'(c.s);
        hour_adv = 1'b0;
        if (r) begin
            h = 12; m = 0; s = 0; n.pm = 1'b0;
        end else if (ah || am || as) begin
            if (as) s = 0;
            if (am) m = (m + 1) % 60;
            hour_adv = ah;
        end else if (t) begin
            s = s + 1;
            if (s == 60) begin
                s = 0;
                m = m + 1;
                if (m == 60) begin
                    m = 0;
                    hour_adv = 1'b1;
`ifdef BCD_CLOCK_12H_EN
                    n.dw = (h == 11) && c.pm;
`else
                    n.dw = (h == 23);
`endif
                end
            end
        end
        if (hour_adv) begin
`ifdef BCD_CLOCK_12H_EN
            if (h == 11) n.pm = ~c.pm;
`endif
            h = next_hour(h);
        end
        n.h = 5'(h); n.m = 6'(m); n.s = 6'(s);
        return n;
    endfunction

    // Reference model advances on the same edge as the DUT.
    always @(posedge clk) begin
        mdl <= step(mdl, reset, tick, adj_hrs, adj_mins, adj_secs);
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({hrs, mins, secs, day_wrap, pm} !==
                {bcd(int'(mdl.h)), bcd(int'(mdl.m)), bcd(int'(mdl.s)), mdl.dw, mdl.pm}) begin
                errors++;
                $display("FAIL model t=%0t dut=%h:%h:%h dw=%b pm=%b exp=%h:%h:%h dw=%b pm=%b",
                         $time, hrs, mins, secs, day_wrap, pm, bcd(int'(mdl.h)),
                         bcd(int'(mdl.m)), bcd(int'(mdl.s)), mdl.dw, mdl.pm);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_time(input string name, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s, input logic dw);
        chk({name, "_hrs"}, hrs, h);
        chk({name, "_mins"}, mins, m);
        chk({name, "_secs"}, secs, s);
        chk({name, "_dw"}, {7'd0, day_wrap}, {7'd0, dw});
    endtask

    // Hold the strobes across one rising edge, then release them.
    task automatic apply(input logic r, input logic t, input logic ah,
                         input logic am, input logic as);
        reset = r; tick = t; adj_hrs = ah; adj_mins = am; adj_secs = as;
        @(posedge clk);
        #1;
        reset = 1'b0; tick = 1'b0; adj_hrs = 1'b0; adj_mins = 1'b0; adj_secs = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; adj_hrs = 1'b0; adj_mins = 1'b0; adj_secs = 1'b0;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("reset_tick", 8'h12, 8'h00, 8'h00, 1'b0);
        chk("reset_pm", {7'd0, pm}, 8'h00);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_time("after_reset", 8'h12, 8'h00, 8'h00, 1'b0);

`ifdef BCD_CLOCK_12H_EN
        repeat (23) apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (59) apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (59) apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("pm_115959", 8'h11, 8'h59, 8'h59, 1'b0);
        chk("pm_set", {7'd0, pm}, 8'h01);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("wrap12", 8'h12, 8'h00, 8'h00, 1'b1);
        chk("wrap12_pm", {7'd0, pm}, 8'h00);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_time("adj12_01", 8'h01, 8'h00, 8'h00, 1'b0);
        chk("adj12_pm", {7'd0, pm}, 8'h00);
`else
        repeat (11) apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (59) apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (58) apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("load_235958", 8'h23, 8'h59, 8'h58, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("tick_235959", 8'h23, 8'h59, 8'h59, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("day_wrap", 8'h00, 8'h00, 8'h00, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_time("dw_one_cycle", 8'h00, 8'h00, 8'h00, 1'b0);

        repeat (59) apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (30) apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("load_005930", 8'h00, 8'h59, 8'h30, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_time("adj_mins_nocarry", 8'h00, 8'h00, 8'h30, 1'b0);

        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_time("adj_secs_clr", 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (9) apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_time("tick_dropped", 8'h00, 8'h01, 8'h09, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("lone_tick", 8'h00, 8'h01, 8'h10, 1'b0);

        for (int i = 1; i <= 25; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("adj_hrs_seq", hrs, bcd(i % 24));
            chk("adj_hrs_no_dw", {7'd0, day_wrap}, 8'h00);
        end
`endif

        for (int i = 0; i < 4000; i++) begin
            apply(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 63) == 0));
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
